reset_release_seq: RTL and testbench

Staged reset-release sequencer sitting downstream of the reset pulse generator. Takes the stretched reset request, holds up to STAGES downstream reset domains in reset, then releases them one at a time in index order. Before each next release it waits for that stage's ready/lock acknowledge, bounded by a timeout. It reports overall completion and the stage that failed.

---
 rtl/reset_release_seq_if.sv | 32 +++
 rtl/reset_release_seq.sv | 158 +++++++++++++++
 tb/tb_reset_release_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/reset_release_seq_if.sv
// Handshake bundle for reset_release_seq: reset request, per-stage ready in;
// per-stage resets and completion/timeout status out.
interface reset_release_seq_if #(
  parameter int unsigned STAGES = 4
);
  logic              ip_reset_i;
  logic [STAGES-1:0] ip_ready_i;
  logic [STAGES-1:0] op_stage_reset_o;
  logic              op_done_o;
  logic              op_timeout_o;
  logic [2:0]        op_fail_stage_o;

  // Sequencer side.
  modport slave (
    input  ip_reset_i,
    input  ip_ready_i,
    output op_stage_reset_o,
    output op_done_o,
    output op_timeout_o,
    output op_fail_stage_o
  );

  // Reset source / downstream-domain side.
  modport master (
    output ip_reset_i,
    output ip_ready_i,
    input  op_stage_reset_o,
    input  op_done_o,
    input  op_timeout_o,
    input  op_fail_stage_o
  );
endinterface

// File: rtl/reset_release_seq.sv
// Staged reset-release sequencer: releases STAGES reset domains in index order,
// waiting for each stage's ready with a timeout. Optional RESET_SEQ_READY_MON_EN
// restarts the sequence when any ready drops while DONE.
module reset_release_seq #(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic ip_async_reset_i,
  reset_release_seq_if.slave rs
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(STAGES - 1);

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic [31:0]       timer, timer_nxt;
  logic [STAGES-1:0] stage_rst, stage_rst_nxt;
  logic              done, done_nxt;
  logic              timeout, timeout_nxt;
  logic [2:0]        fail_stage, fail_stage_nxt;

  logic [STAGES-1:0] cur_mask;
  logic              ready_sel;

  // One-hot of the current stage; avoids indexing the vectors with a 3-bit idx.
  always_comb begin
    cur_mask  = '0;
    ready_sel = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      cur_mask[i] = (i[2:0] == idx);
      ready_sel   = ready_sel | (rs.ip_ready_i[i] & cur_mask[i]);
    end
  end

  always_ff @(posedge clk or posedge ip_async_reset_i) begin
    if (ip_async_reset_i) begin
      state      <= S_HOLD;
      idx        <= '0;
      cnt        <= '0;
      timer      <= '0;
      stage_rst  <= '1;
      done       <= 1'b0;
      timeout    <= 1'b0;
      fail_stage <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      timer      <= timer_nxt;
      stage_rst  <= stage_rst_nxt;
      done       <= done_nxt;
      timeout    <= timeout_nxt;
      fail_stage <= fail_stage_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    timer_nxt      = timer;
    stage_rst_nxt  = stage_rst;
    done_nxt       = done;
    timeout_nxt    = timeout;
    fail_stage_nxt = fail_stage;

    if (rs.ip_reset_i) begin
      state_nxt      = S_HOLD;
      idx_nxt        = '0;
      cnt_nxt        = '0;
      timer_nxt      = '0;
      stage_rst_nxt  = '1;
      done_nxt       = 1'b0;
      timeout_nxt    = 1'b0;
      fail_stage_nxt = '0;
    end else begin
      case (state)
        S_HOLD: begin
          state_nxt = S_DELAY;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end

        S_DELAY: begin
          cnt_nxt = cnt + 32'd1;
          if (cnt == STAGE_DELAY - 1) begin
            stage_rst_nxt = stage_rst & ~cur_mask;
            state_nxt     = S_WAIT;
            timer_nxt     = '0;
          end
        end

        // Ready is checked before the timeout so a same-edge ack wins.
        S_WAIT: begin
          if (ready_sel) begin
            if (idx == LAST_IDX) begin
              state_nxt     = S_DONE;
              done_nxt      = 1'b1;
              stage_rst_nxt = '0;
            end else begin
              idx_nxt   = idx + 3'd1;
              cnt_nxt   = '0;
              state_nxt = S_DELAY;
            end
          end else if (timer == TIMEOUT - 1) begin
            state_nxt      = S_FAIL;
            stage_rst_nxt  = '1;
            timeout_nxt    = 1'b1;
            fail_stage_nxt = idx;
          end else begin
            timer_nxt = timer + 32'd1;
          end
        end

        S_DONE: begin
          stage_rst_nxt = '0;
          done_nxt      = 1'b1;
`ifdef RESET_SEQ_READY_MON_EN
          if (!(&rs.ip_ready_i)) begin
            stage_rst_nxt = '1;
            done_nxt      = 1'b0;
            state_nxt     = S_DELAY;
            idx_nxt       = '0;
            cnt_nxt       = '0;
          end
`endif
        end

        S_FAIL: begin
          state_nxt = S_FAIL;
        end

        default: begin
          state_nxt     = S_HOLD;
          stage_rst_nxt = '1;
          done_nxt      = 1'b0;
        end
      endcase
    end
  end

  assign rs.op_stage_reset_o = stage_rst;
  assign rs.op_done_o        = done;
  assign rs.op_timeout_o     = timeout;
  assign rs.op_fail_stage_o  = fail_stage;

endmodule

// File: tb/tb_reset_release_seq.sv
// Directed bench for reset_release_seq (STAGES=3, STAGE_DELAY=4, TIMEOUT=8).
// obs packs {stage_reset[2:0], done, timeout, fail_stage[2:0]}.
module tb_reset_release_seq;

  logic clk = 1'b0;
  logic arst;
  int   tests = 0;
  int   fails = 0;

  reset_release_seq_if #(.STAGES(3)) rs ();

  reset_release_seq #(
    .STAGES(3),
    .STAGE_DELAY(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .ip_async_reset_i(arst),
    .rs(rs)
  );

  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {rs.op_stage_reset_o, rs.op_done_o, rs.op_timeout_o, rs.op_fail_stage_o};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves time just after E0 (the edge sampling ip_reset_i low).
  task automatic start_seq();
    rs.ip_reset_i = 1'b1;
    tick(1);
    rs.ip_reset_i = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    rs.ip_reset_i = 1'b1;
    rs.ip_ready_i = 3'b000;
    #3;
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL reset_async: got %b exp %b", obs, 8'b111_0_0_000); end
    tick(2);
    arst = 1'b0;
    tick(3);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL reset_hold: got %b exp %b", obs, 8'b111_0_0_000); end
  endtask

  task automatic test_nominal();
    rs.ip_ready_i = 3'b111;
    start_seq();
    tick(3);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL nominal_E0+3: got %b exp %b", obs, 8'b111_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL nominal_E0+4: got %b exp %b", obs, 8'b110_0_0_000); end
    tick(4);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL nominal_E0+8: got %b exp %b", obs, 8'b110_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL nominal_E0+9: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(4);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL nominal_E0+13: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b000_0_0_000) begin fails++; $display("FAIL nominal_E0+14: got %b exp %b", obs, 8'b000_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL nominal_done_E0+15: got %b exp %b", obs, 8'b000_1_0_000); end
  endtask

  task automatic test_timeout();
    rs.ip_ready_i = 3'b101;
    start_seq();
    tick(9);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL timeout_rel1_E0+9: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(7);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL timeout_pre_E0+16: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b111_0_1_001) begin fails++; $display("FAIL timeout_fail_E0+17: got %b exp %b", obs, 8'b111_0_1_001); end
    rs.ip_ready_i = 3'b111;
    tick(5);
    tests++; if (obs !== 8'b111_0_1_001) begin fails++; $display("FAIL timeout_sticky: got %b exp %b", obs, 8'b111_0_1_001); end
    rs.ip_reset_i = 1'b1;
    tick(1);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL timeout_clear: got %b exp %b", obs, 8'b111_0_0_000); end
  endtask

  task automatic test_timeout_tie();
    rs.ip_ready_i = 3'b101;
    start_seq();
    tick(16);
    rs.ip_ready_i = 3'b111;
    tick(1);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL tie_E0+17: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(3);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL tie_E0+20: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b000_0_0_000) begin fails++; $display("FAIL tie_rel2_E0+21: got %b exp %b", obs, 8'b000_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL tie_done_E0+22: got %b exp %b", obs, 8'b000_1_0_000); end
  endtask

  task automatic test_async_mid();
    rs.ip_ready_i = 3'b111;
    start_seq();
    tick(7);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL async_pre_E0+7: got %b exp %b", obs, 8'b110_0_0_000); end
    #2;
    arst = 1'b1;
    #1;
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL async_immediate: got %b exp %b", obs, 8'b111_0_0_000); end
    rs.ip_reset_i = 1'b1;
    #1;
    arst = 1'b0;
    start_seq();
    tick(4);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL async_rerun_E0+4: got %b exp %b", obs, 8'b110_0_0_000); end
    tick(5);
    tests++; if (obs !== 8'b100_0_0_000) begin fails++; $display("FAIL async_rerun_E0+9: got %b exp %b", obs, 8'b100_0_0_000); end
    tick(5);
    tests++; if (obs !== 8'b000_0_0_000) begin fails++; $display("FAIL async_rerun_E0+14: got %b exp %b", obs, 8'b000_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL async_rerun_done: got %b exp %b", obs, 8'b000_1_0_000); end
  endtask

  // Entered in DONE.
  task automatic test_reset_in_done();
    rs.ip_reset_i = 1'b1;
    tick(1);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL done_rst_pulse: got %b exp %b", obs, 8'b111_0_0_000); end
    rs.ip_reset_i = 1'b0;
    tick(1);
    tick(3);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL done_rst_E0+3: got %b exp %b", obs, 8'b111_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL done_rst_E0+4: got %b exp %b", obs, 8'b110_0_0_000); end
    tick(11);
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL done_rst_redone: got %b exp %b", obs, 8'b000_1_0_000); end
  endtask

  // Entered in DONE.
  task automatic test_ready_drop_done();
    rs.ip_ready_i = 3'b110;
    tick(1);
    rs.ip_ready_i = 3'b111;
`ifdef RESET_SEQ_READY_MON_EN
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL mon_drop_edge: got %b exp %b", obs, 8'b111_0_0_000); end
    tick(3);
    tests++; if (obs !== 8'b111_0_0_000) begin fails++; $display("FAIL mon_drop_+3: got %b exp %b", obs, 8'b111_0_0_000); end
    tick(1);
    tests++; if (obs !== 8'b110_0_0_000) begin fails++; $display("FAIL mon_drop_+4: got %b exp %b", obs, 8'b110_0_0_000); end
`else
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL nomon_drop_edge: got %b exp %b", obs, 8'b000_1_0_000); end
    tick(4);
    tests++; if (obs !== 8'b000_1_0_000) begin fails++; $display("FAIL nomon_drop_+4: got %b exp %b", obs, 8'b000_1_0_000); end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_timeout_tie();
    test_async_mid();
    test_reset_in_done();
    test_ready_drop_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
